vga_draw_sequencer: RTL and testbench

- Sequences all pixel writes into the VGA adapter once per frame.
- On each V_SYNC falling edge it draws:
  - a full-screen background from a selected ROM;
  - then every rectangular sprite job queued by game logic (digits, cursor, icons), in FIFO order.
- Generates ROM read addresses plus a ROM select.
- Emits pipeline-aligned x/y/writeEn so the external colour mux lines up with synchronous ROM latency.
- Replaces ad-hoc per-screen draw logic in the VGA control path.

---
 rtl/vga_pkg.sv | 51 +++++
 rtl/draw_job_fifo.sv | 61 ++++++
 rtl/vga_draw_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_vga_draw_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA draw path:
// screen size, ROM ids, sequencer states and the queued job record.
package vga_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int SRCW  = 4;
  localparam int ADDRW = 17;

  localparam logic [SRCW-1:0] MENU   = 4'd0;
  localparam logic [SRCW-1:0] RED    = 4'd1;
  localparam logic [SRCW-1:0] GREEN  = 4'd2;
  localparam logic [SRCW-1:0] BLUE   = 4'd3;
  localparam logic [SRCW-1:0] SCORE  = 4'd4;
  localparam logic [SRCW-1:0] DIGIT0 = 4'd5;
  localparam logic [SRCW-1:0] DIGIT1 = 4'd6;
  localparam logic [SRCW-1:0] DIGIT2 = 4'd7;
  localparam logic [SRCW-1:0] DIGIT3 = 4'd8;
  localparam logic [SRCW-1:0] DIGIT4 = 4'd9;
  localparam logic [SRCW-1:0] DIGIT5 = 4'd10;
  localparam logic [SRCW-1:0] DIGIT6 = 4'd11;
  localparam logic [SRCW-1:0] DIGIT7 = 4'd12;
  localparam logic [SRCW-1:0] DIGIT8 = 4'd13;
  localparam logic [SRCW-1:0] DIGIT9 = 4'd14;
  localparam logic [SRCW-1:0] CURSOR = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    BACK,
    FETCH,
    SPRITE,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [XW-1:0]   w;
    logic [YW-1:0]   h;
    logic [SRCW-1:0] src;
  } job_t;

  typedef struct packed {
    logic            we;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [SRCW-1:0] sel;
  } pix_t;
endpackage

// File: rtl/draw_job_fifo.sv
// Single-clock job FIFO with registered count and full/empty flags.
// A push while full or a pop while empty is ignored.
module draw_job_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic iReset,
  input  logic push,
  input  job_t pushJob,
  input  logic pop,
  output job_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  job_t mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0] count;
  logic [AW:0] countNext;
  logic doPush;
  logic doPop;

  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr];

  always_comb begin
    countNext = count;
    if (doPush && !doPop)
      countNext = count + (AW+1)'(1);
    else if (doPop && !doPush)
      countNext = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + AW'(1);
      if (doPop)
        rdPtr <= rdPtr + AW'(1);
      count <= countNext;
      full  <= (countNext == (AW+1)'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr] <= pushJob;
  end
endmodule

// File: rtl/vga_draw_sequencer.sv
// Per-frame pixel sequencer: background raster, then queued sprite jobs,
// with x/y/romSel/writeEn delayed to line up with synchronous ROM data.
module vga_draw_sequencer
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H,
  parameter int QDEPTH   = 8,
  parameter int ROM_LAT  = 1
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic             V_SYNC,
  input  logic [SRCW-1:0]  bgSel,
  input  logic             jobValid,
  output logic             jobReady,
  input  logic [XW-1:0]    jobX,
  input  logic [YW-1:0]    jobY,
  input  logic [XW-1:0]    jobW,
  input  logic [YW-1:0]    jobH,
  input  logic [SRCW-1:0]  jobSrc,
  output logic [ADDRW-1:0] romAddr,
  output logic [SRCW-1:0]  romSel,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic             writeEn,
  output logic             busy,
  output logic             frameDone,
  output logic             overrun
);
  localparam int FW = 2;

  state_t state;
  state_t stateNext;
  job_t jobIn;
  job_t head;
  logic fifoFull;
  logic fifoEmpty;
  logic vSyncPrev;
  logic frameStart;
  logic issue;
  logic pop;
  logic lastPix;
  logic flushLast;
  logic [XW-1:0] orgX;
  logic [XW-1:0] wReg;
  logic [XW-1:0] col;
  logic [YW-1:0] orgY;
  logic [YW-1:0] hReg;
  logic [YW-1:0] row;
  logic [SRCW-1:0] src;
  logic [ADDRW-1:0] addr;
  logic [FW-1:0] flushCnt;
  logic [XW:0] px;
  logic [YW:0] py;
  pix_t cur;
  pix_t pipe [ROM_LAT];

  assign jobIn = '{x: jobX, y: jobY, w: jobW, h: jobH, src: jobSrc};
  assign frameStart = vSyncPrev & ~V_SYNC;
  assign lastPix = (col == wReg - XW'(1)) &&
                   (row == hReg - YW'(1));
  assign flushLast = (flushCnt == FW'(ROM_LAT - 1));
  assign jobReady = ~fifoFull;
  assign romAddr = addr;
  assign busy = (state != IDLE);

  draw_job_fifo #(
    .DEPTH(QDEPTH)
  ) uFifo (
    .clk,
    .iReset,
    .push(jobValid),
    .pushJob(jobIn),
    .pop,
    .head,
    .full(fifoFull),
    .empty(fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (iReset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:
        if (frameStart)
          stateNext = BACK;
      BACK, SPRITE:
        if (lastPix)
          stateNext = FETCH;
      FETCH:
        if (fifoEmpty)
          stateNext = FLUSH;
        else if (head.w == '0 || head.h == '0)
          stateNext = FETCH;
        else
          stateNext = SPRITE;
      FLUSH:
        if (flushLast)
          stateNext = IDLE;
      default:
        stateNext = IDLE;
    endcase
  end

  // Clip test runs one bit wider so sprites past the right/bottom never wrap
  always_comb begin
    issue = 1'b0;
    pop   = 1'b0;
    unique case (state)
      BACK, SPRITE: issue = 1'b1;
      FETCH:        pop   = ~fifoEmpty;
      default:      ;
    endcase
    px = {1'b0, orgX} + {1'b0, col};
    py = {1'b0, orgY} + {1'b0, row};
    cur.we  = issue &&
              (px < (XW+1)'(SCREEN_W)) &&
              (py < (YW+1)'(SCREEN_H));
    cur.x   = px[XW-1:0];
    cur.y   = py[YW-1:0];
    cur.sel = src;
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      vSyncPrev <= 1'b0;
      orgX      <= '0;
      orgY      <= '0;
      wReg      <= '0;
      hReg      <= '0;
      src       <= '0;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      flushCnt  <= '0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      vSyncPrev <= V_SYNC;
      if (state == IDLE && frameStart) begin
        orgX <= '0;
        orgY <= '0;
        wReg <= XW'(SCREEN_W);
        hReg <= YW'(SCREEN_H);
        src  <= bgSel;
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (pop) begin
        orgX <= head.x;
        orgY <= head.y;
        wReg <= head.w;
        hReg <= head.h;
        src  <= head.src;
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (issue) begin
        addr <= addr + ADDRW'(1);
        if (col == wReg - XW'(1)) begin
          col <= '0;
          row <= row + YW'(1);
        end else begin
          col <= col + XW'(1);
        end
      end
      flushCnt  <= (state == FLUSH) ? flushCnt + FW'(1) : '0;
      frameDone <= (state == FLUSH) && flushLast;
      overrun   <= frameStart && (state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      for (int i = 0; i < ROM_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < ROM_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign writeEn = pipe[ROM_LAT-1].we;
  assign x       = pipe[ROM_LAT-1].x;
  assign y       = pipe[ROM_LAT-1].y;
  assign romSel  = pipe[ROM_LAT-1].sel;
endmodule

// File: tb/tb_vga_draw_sequencer.sv
// Scoreboard bench for vga_draw_sequencer on a reduced 40x30 screen.
// The reference model rasterises each frame straight from its job list.
`timescale 1ns/1ps
module tb_vga_draw_sequencer;
  import vga_pkg::*;

  localparam int SW  = 40;
  localparam int SH  = 30;
  localparam int QD  = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic iReset;
  logic V_SYNC;
  logic [3:0] bgSel;
  logic jobValid;
  logic jobReady;
  logic [8:0] jobX;
  logic [7:0] jobY;
  logic [8:0] jobW;
  logic [7:0] jobH;
  logic [3:0] jobSrc;
  logic [16:0] romAddr;
  logic [3:0] romSel;
  logic [8:0] x;
  logic [7:0] y;
  logic writeEn;
  logic busy;
  logic frameDone;
  logic overrun;

  always #5 clk = ~clk;

  vga_draw_sequencer #(
    .SCREEN_W(SW),
    .SCREEN_H(SH),
    .QDEPTH(QD),
    .ROM_LAT(LAT)
  ) dut (
    .clk(clk),
    .iReset(iReset),
    .V_SYNC(V_SYNC),
    .bgSel(bgSel),
    .jobValid(jobValid),
    .jobReady(jobReady),
    .jobX(jobX),
    .jobY(jobY),
    .jobW(jobW),
    .jobH(jobH),
    .jobSrc(jobSrc),
    .romAddr(romAddr),
    .romSel(romSel),
    .x(x),
    .y(y),
    .writeEn(writeEn),
    .busy(busy),
    .frameDone(frameDone),
    .overrun(overrun)
  );

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    int src;
  } tjob_t;

  typedef struct {
    int x;
    int y;
    int sel;
    int addr;
  } pix_e;

  tjob_t mq[$];
  pix_e expQ[$];
  int lenQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int doneCnt = 0;
  int framesExp = 0;
  int ovrCnt = 0;
  int ovrExp = 0;
  int prevAddr = 0;
  bit prevBusy = 1'b0;
  bit inFrame = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    pix_e e;
    cyc++;
    if (busy && !prevBusy)
      startCyc = cyc;
    prevBusy = busy;
    if (writeEn) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL pixel: got write x=%0d y=%0d sel=%0d, expected none",
                 x, y, romSel);
      end else begin
        e = expQ.pop_front();
        if (x != e.x || y != e.y || romSel != e.sel || prevAddr != e.addr) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d sel=%0d addr=%0d expected x=%0d y=%0d sel=%0d addr=%0d",
                   x, y, romSel, prevAddr, e.x, e.y, e.sel, e.addr);
        end
      end
    end
    if (frameDone) begin
      doneCnt++;
      if (lenQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frameDone: got pulse expected none");
      end else begin
        chk("frameLen", cyc - startCyc, lenQ.pop_front());
      end
      chk("writesLeft", expQ.size(), 0);
    end
    if (overrun)
      ovrCnt++;
    prevAddr = int'(romAddr);
  end

  // Model: background then every queued job, row-major, clipped to screen
  task automatic buildFrame(input int bg);
    tjob_t j;
    int len;
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        expQ.push_back('{c, r, bg, r * SW + c});
    len = SW * SH;
    while (mq.size() > 0) begin
      j = mq.pop_front();
      len += j.w * j.h + 1;
      for (int r = 0; r < j.h; r++)
        for (int c = 0; c < j.w; c++)
          if (j.x + c < SW && j.y + r < SH)
            expQ.push_back('{j.x + c, j.y + r, j.src, r * j.w + c});
    end
    len += 1 + LAT;
    lenQ.push_back(len);
    framesExp++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushJob(input int jx, input int jy, input int jw,
                         input int jh, input int js);
    jobX = 9'(jx);
    jobY = 8'(jy);
    jobW = 9'(jw);
    jobH = 8'(jh);
    jobSrc = 4'(js);
    jobValid = 1'b1;
    @(negedge clk);
    chk("jobReady", jobReady, mq.size() < QD);
    if (mq.size() < QD)
      mq.push_back('{jx, jy, jw, jh, js});
    tick();
    jobValid = 1'b0;
  endtask

  task automatic startFrame(input int bg);
    bgSel = 4'(bg);
    V_SYNC = 1'b0;
    if (inFrame)
      ovrExp++;
    else
      buildFrame(bg);
    inFrame = 1'b1;
    tick();
    tick();
    V_SYNC = 1'b1;
    tick();
  endtask

  task automatic waitFrame();
    int n;
    n = 0;
    while (doneCnt < framesExp && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("framesDone", doneCnt, framesExp);
    inFrame = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int nj;
    iReset = 1'b1;
    V_SYNC = 1'b1;
    bgSel = '0;
    jobValid = 1'b0;
    jobX = '0;
    jobY = '0;
    jobW = '0;
    jobH = '0;
    jobSrc = '0;
    repeat (3) tick();
    iReset = 1'b0;
    @(negedge clk);
    chk("rstBusy", busy, 0);
    chk("rstWriteEn", writeEn, 0);
    chk("rstJobReady", jobReady, 1);
    chk("rstFrameDone", frameDone, 0);
    chk("rstOverrun", overrun, 0);
    chk("rstRomAddr", romAddr, 0);
    chk("rstXY", {x, y, romSel}, 0);
    tick();

    startFrame(2);
    waitFrame();

    pushJob(12, 10, 17, 17, DIGIT3);
    pushJob(29, 10, 17, 17, DIGIT7);
    startFrame(MENU);
    waitFrame();

    pushJob(SW - 10, SH - 5, 16, 16, CURSOR);
    startFrame(RED);
    waitFrame();

    pushJob(3, 3, 0, 5, SCORE);
    pushJob(7, 8, 4, 4, BLUE);
    pushJob(9, 9, 6, 0, SCORE);
    startFrame(GREEN);
    waitFrame();

    for (int i = 0; i < 8; i++)
      pushJob(i * 4, i * 3, 3, 2, DIGIT0 + i);
    jobX = 9'd1;
    jobY = 8'd1;
    jobW = 9'd2;
    jobH = 8'd2;
    jobSrc = DIGIT9;
    jobValid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("jobReadyHeld", jobReady, mq.size() < QD);
      tick();
    end
    jobValid = 1'b0;
    startFrame(MENU);
    repeat (100) tick();
    startFrame(BLUE);
    waitFrame();
    chk("overrunCount", ovrCnt, ovrExp);

    pushJob(5, 5, 10, 10, SCORE);
    pushJob(0, 0, 3, 3, BLUE);
    startFrame(RED);
    repeat (SW * SH + 20) tick();
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    expQ.delete();
    lenQ.delete();
    mq.delete();
    framesExp = doneCnt;
    inFrame = 1'b0;
    @(negedge clk);
    chk("midRstBusy", busy, 0);
    chk("midRstWriteEn", writeEn, 0);
    chk("midRstJobReady", jobReady, 1);
    tick();
    startFrame(GREEN);
    waitFrame();

    repeat (4) begin
      nj = $urandom_range(1, 7);
      for (int k = 0; k < nj; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        pushJob(($urandom_range(0, 3) == 0) ? $urandom_range(0, 511)
                                            : $urandom_range(0, SW + 5),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                            : $urandom_range(0, SH + 5),
                $urandom_range(0, 14), $urandom_range(0, 14),
                $urandom_range(0, 15));
      end
      startFrame($urandom_range(0, 15));
      waitFrame();
    end
    chk("overrunFinal", ovrCnt, ovrExp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
